// File: rtl/bmp_gray_blur3x3.sv
// Streaming 24-bit pixel -> 8-bit luma -> 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16).
// Optional macro BMPF_THRESHOLD_EN adds a threshold port and binarises the output.
module bmp_gray_blur3x3 #(
  parameter int MAX_WIDTH = 2048,
  parameter int AW        = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] img_width,
  input  logic [31:0] img_height,
  input  logic        in_valid,
  input  logic [23:0] in_pixel,
`ifdef BMPF_THRESHOLD_EN
  input  logic [7:0]  threshold,
`endif
  output logic        out_valid,
  output logic [23:0] out_pixel,
  output logic [15:0] out_col,
  output logic [15:0] out_row,
  output logic        out_done,
  output logic        cfg_err,
  output logic        in_overrun
);

  // state | meaning
  // RUN   | accepting input pixels
  // FLUSH | W+1 internal zero pushes to complete the last rows
  // DRAIN | 2 cycles emptying the window/filter stages
  // DONE  | frame complete (or config error), held until rst
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, DONE} state_t;

  state_t      state_q;
  logic [15:0] w_q, h_q, in_col_q, cnt_q, oc_q, or_q;
  logic [31:0] in_idx_q;
  logic        out_done_q, cfg_err_q, overrun_q;
`ifdef BMPF_THRESHOLD_EN
  logic [7:0]  thr_q;
`endif

  logic          s1_vld_q, s1_emit_q;
  logic [7:0]    s1_y_q;
  logic [AW-1:0] s1_col_q;
  logic [7:0]    lb0_q [MAX_WIDTH];
  logic [7:0]    lb1_q [MAX_WIDTH];
  logic [7:0]    l_top_q, l_mid_q, l_bot_q, m_top_q, m_mid_q, m_bot_q;

  logic        out_valid_q;
  logic [23:0] out_pixel_q;
  logic [15:0] out_col_q, out_row_q;

  logic        cfg_bad, push, emit, border;
  logic [31:0] total;
  logic [15:0] acc_d, in_col_d;
  logic [7:0]  y_d, r_top, r_mid, filt_d, yo_d;
  logic [11:0] sum_d;
  logic        unused_hi;

  assign unused_hi = &{1'b0, img_width[31:16], img_height[31:16]};

  assign cfg_bad  = ({16'd0, w_q} > 32'(MAX_WIDTH)) || (w_q == 16'd0) || (h_q == 16'd0);
  assign total    = {16'd0, w_q} * {16'd0, h_q};
  assign push     = ((state_q == RUN) && !cfg_bad && in_valid) || (state_q == FLUSH);
  assign emit     = in_idx_q >= ({16'd0, w_q} + 32'd1);
  assign in_col_d = (in_col_q == w_q - 16'd1) ? 16'd0 : in_col_q + 16'd1;

  assign acc_d = 16'd29  * {8'd0, in_pixel[23:16]}
               + 16'd150 * {8'd0, in_pixel[15:8]}
               + 16'd77  * {8'd0, in_pixel[7:0]};
  assign y_d   = (state_q == RUN) ? 8'(acc_d >> 8) : 8'd0;

  // Right window column is formed combinationally from the line buffers and S1 luma.
  assign r_top = lb1_q[s1_col_q];
  assign r_mid = lb0_q[s1_col_q];
  assign sum_d = {4'd0, l_top_q} + {3'd0, m_top_q, 1'b0} + {4'd0, r_top}
               + {3'd0, l_mid_q, 1'b0} + {2'd0, m_mid_q, 2'b0} + {3'd0, r_mid, 1'b0}
               + {4'd0, l_bot_q} + {3'd0, m_bot_q, 1'b0} + {4'd0, s1_y_q};
  assign border = (or_q == 16'd0) || (or_q == h_q - 16'd1)
               || (oc_q == 16'd0) || (oc_q == w_q - 16'd1);
  assign filt_d = border ? m_mid_q : 8'(sum_d >> 4);
`ifdef BMPF_THRESHOLD_EN
  assign yo_d = (filt_d >= thr_q) ? 8'hFF : 8'h00;
`else
  assign yo_d = filt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      in_col_q   <= 16'd0;
      in_idx_q   <= 32'd0;
      cnt_q      <= 16'd0;
      out_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      w_q        <= img_width[15:0];
      h_q        <= img_height[15:0];
`ifdef BMPF_THRESHOLD_EN
      thr_q      <= threshold;
`endif
    end else begin
      if (push) begin
        in_idx_q <= in_idx_q + 32'd1;
        in_col_q <= in_col_d;
      end
      if (in_valid && (state_q != RUN)) overrun_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (cfg_bad) begin
            cfg_err_q  <= 1'b1;
            out_done_q <= 1'b1;
            state_q    <= DONE;
          end else if (in_valid && (in_idx_q == total - 32'd1)) begin
            state_q <= FLUSH;
            cnt_q   <= w_q;
          end
        end
        FLUSH: begin
          if (cnt_q == 16'd0) begin
            state_q <= DRAIN;
            cnt_q   <= 16'd1;
          end else cnt_q <= cnt_q - 16'd1;
        end
        DRAIN: begin
          if (cnt_q == 16'd0) begin
            state_q    <= DONE;
            out_done_q <= 1'b1;
          end else cnt_q <= cnt_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Line buffers and window registers carry no reset; the valid flags gate their use.
  always_ff @(posedge clk) begin
    s1_y_q   <= y_d;
    s1_col_q <= in_col_q[AW-1:0];
    if (s1_vld_q) begin
      lb0_q[s1_col_q] <= s1_y_q;
      lb1_q[s1_col_q] <= r_mid;
      l_top_q <= m_top_q;  l_mid_q <= m_mid_q;  l_bot_q <= m_bot_q;
      m_top_q <= r_top;    m_mid_q <= r_mid;    m_bot_q <= s1_y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_emit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= 24'd0;
      out_col_q   <= 16'd0;
      out_row_q   <= 16'd0;
      oc_q        <= 16'd0;
      or_q        <= 16'd0;
    end else begin
      s1_vld_q    <= push;
      s1_emit_q   <= push && emit;
      out_valid_q <= s1_emit_q;
      if (s1_emit_q) begin
        out_pixel_q <= {3{yo_d}};
        out_col_q   <= oc_q;
        out_row_q   <= or_q;
        if (oc_q == w_q - 16'd1) begin
          oc_q <= 16'd0;
          or_q <= or_q + 16'd1;
        end else oc_q <= oc_q + 16'd1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign out_done   = out_done_q;
  assign cfg_err    = cfg_err_q;
  assign in_overrun = overrun_q;

endmodule

// File: tb/tb_bmp_gray_blur3x3.sv
// Scoreboard bench for bmp_gray_blur3x3: stimulus queues expected pixels, a negedge monitor compares.
module tb_bmp_gray_blur3x3;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] img_width = 32'd4, img_height = 32'd4;
  logic        in_valid = 1'b0;
  logic [23:0] in_pixel = 24'd0;
`ifdef BMPF_THRESHOLD_EN
  logic [7:0]  threshold = 8'h20;
`endif
  logic        out_valid, out_done, cfg_err, in_overrun;
  logic [23:0] out_pixel;
  logic [15:0] out_col, out_row;

  bmp_gray_blur3x3 dut (
    .clk(clk), .rst(rst), .img_width(img_width), .img_height(img_height),
    .in_valid(in_valid), .in_pixel(in_pixel),
`ifdef BMPF_THRESHOLD_EN
    .threshold(threshold),
`endif
    .out_valid(out_valid), .out_pixel(out_pixel), .out_col(out_col), .out_row(out_row),
    .out_done(out_done), .cfg_err(cfg_err), .in_overrun(in_overrun));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [23:0] pix; logic [15:0] col; logic [15:0] row;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, failures = 0, n_out = 0;
  int last_out_cyc = 0, first_out_cyc = -1, done_cyc = -1;
  bit mon_ignore = 1'b0;

  logic [23:0] t5_pix [6] = '{24'hFFFFFF, 24'h000000, 24'h808080, 24'h00FF00, 24'hFF0000, 24'h0000FF};
  logic [7:0]  t5_y   [6] = '{8'hFF, 8'h00, 8'h80, 8'h95, 8'h1C, 8'h4C};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_done && done_cyc < 0) done_cyc = cyc;
    if (out_valid && !mon_ignore) begin
      n_out++;
      last_out_cyc = cyc;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out got pix=%h col=%0d row=%0d exp=none", out_pixel, out_col, out_row);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pixel", out_pixel, mon_e.pix);
        check("out_col", out_col, mon_e.col);
        check("out_row", out_row, mon_e.row);
      end
    end
  end

  // kinds: 0 flat 0x80, 1 impulse at (2,2), 2 six-pixel luma table (W=2), 3 flat 0x40
  function automatic logic [23:0] pix_of(int kind, int c, int r);
    case (kind)
      0: return 24'h808080;
      1: return (c == 2 && r == 2) ? 24'hFFFFFF : 24'h000000;
      2: return t5_pix[r*2 + c];
      default: return 24'h404040;
    endcase
  endfunction

  function automatic logic [23:0] exp_of(int kind, int c, int r, int w, int h);
    logic [7:0] y;
    int dc, dr;
    bit brd;
    dc  = (c > 2) ? c - 2 : 2 - c;
    dr  = (r > 2) ? r - 2 : 2 - r;
    brd = (c == 0) || (r == 0) || (c == w - 1) || (r == h - 1);
    case (kind)
      0: y = 8'h80;
      1: begin
        if (brd) y = (dc == 0 && dr == 0) ? 8'hFF : 8'h00;
        else if (dc == 0 && dr == 0) y = 8'h3F;
        else if (dc + dr == 1) y = 8'h1F;
        else if (dc == 1 && dr == 1) y = 8'h0F;
        else y = 8'h00;
      end
      2: y = t5_y[r*2 + c];
      default: y = 8'h40;
    endcase
`ifdef BMPF_THRESHOLD_EN
    y = (y >= 8'h20) ? 8'hFF : 8'h00;
`endif
    return {y, y, y};
  endfunction

  task automatic do_reset(input int w, input int h);
    rst = 1'b1;
    in_valid = 1'b0;
    img_width = w;
    img_height = h;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int kind, input bit gap, input bit hold);
    int idx, b, push_cyc, base;
    bit ph;
    do_reset(w, h);
    base = n_out; first_out_cyc = -1; done_cyc = -1; push_cyc = -1;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back(exp_t'{pix: exp_of(kind, c, r, w, h), col: 16'(c), row: 16'(r)});
    idx = 0; ph = 1'b0;
    while (idx < w*h) begin
      if (gap && ph) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_pixel = pix_of(kind, idx % w, idx / w);
        if (idx == w + 1) push_cyc = cyc;
        idx++;
      end
      ph = !ph;
      @(posedge clk); #1;
    end
    in_valid = hold;
    in_pixel = 24'd0;
    b = 0;
    while (!out_done && b < 500) begin @(posedge clk); #1; b++; end
    check("done_reached", out_done, 1);
    @(posedge clk); #1;
    check("output_count", n_out - base, w*h);
    check("queue_empty", exp_q.size(), 0);
    check("done_after_last", done_cyc, last_out_cyc + 1);
    if (push_cyc >= 0 && !gap) check("first_latency", first_out_cyc, push_cyc + 2);
    check("in_overrun", in_overrun, hold);
    check("cfg_err_clear", cfg_err, 0);
    check("valid_low_done", out_valid, 0);
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic cfg_case(input int w, input int h);
    int base;
    do_reset(w, h);
    base = n_out;
    in_valid = 1'b1;
    in_pixel = 24'hFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("cfg_err_set", cfg_err, 1);
    check("cfg_done", out_done, 1);
    check("cfg_no_outputs", n_out - base, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_done", out_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_overrun", in_overrun, 0);

    run_frame(4, 4, 0, 1'b0, 1'b0);   // T1 flat
    run_frame(5, 5, 1, 1'b0, 1'b0);   // T2 impulse
    run_frame(5, 5, 1, 1'b1, 1'b0);   // T3 gapped impulse

    // T4 abort after 7 pushes, then a full new frame
    mon_ignore = 1'b1;
    do_reset(4, 4);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_pixel = 24'h808080;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_pixel", out_pixel, 0);
    mon_ignore = 1'b0;
    run_frame(4, 4, 1, 1'b0, 1'b0);

    run_frame(2, 3, 2, 1'b0, 1'b0);   // T5 all-border pass-through
    cfg_case(2049, 4);
    cfg_case(4, 0);
    run_frame(4, 4, 3, 1'b0, 1'b1);   // T6 overrun

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
